// File: rtl/delay_buff_pkg.sv
// Shared constants, width helper and stage record for the delay_buff line.
// Optional tap bus is enabled with DELAY_BUFF_TAPS_EN.
package delay_buff_pkg;

  localparam int unsigned DEF_WIDTH = 1;
  localparam int unsigned DEF_DEPTH = 4;

  // Default-width stage record; the top re-declares it at its own WIDTH.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic                 valid;
  } stage_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2_fn(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_buff_stage.sv
// One delay-line stage: {data, valid} register with sync reset, flush and enable.
// Used by delay_buff irrespective of DELAY_BUFF_TAPS_EN.
module delay_buff_stage
  import delay_buff_pkg::*;
#(
  parameter type rec_t = delay_buff_pkg::stage_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic en,
  input  rec_t d,
  output rec_t q
);

  rec_t stage_q;
  rec_t stage_d;

  // Flush wins over shift; otherwise hold.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (en) begin
      stage_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q;

endmodule

// File: rtl/delay_buff.sv
// Stallable multi-stage delay line with runtime tap select and fill tracking.
// Define DELAY_BUFF_TAPS_EN to expose every stage on the flattened taps bus.
module delay_buff
  import delay_buff_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned SW    = clog2_fn(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic [SW-1:0]    sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             primed
`ifdef DELAY_BUFF_TAPS_EN
  ,
  output logic [WIDTH*DEPTH-1:0] taps
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
  } stage_w_t;

  stage_w_t      st [DEPTH];
  logic [SW-1:0] cnt_q;
  logic [SW-1:0] cnt_d;
  logic [SW-1:0] sel_eff;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    stage_w_t d_i;

    if (i == 0) begin : g_head
      assign d_i = {in, in_valid};
    end else begin : g_body
      assign d_i = st[i-1];
    end

    delay_buff_stage #(
      .rec_t (stage_w_t)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .en    (en),
      .d     (d_i),
      .q     (st[i])
    );

`ifdef DELAY_BUFF_TAPS_EN
    assign taps[i*WIDTH +: WIDTH] = st[i].data;
`endif
  end

  // Fill counter: shifted cycles since reset/flush, saturating at DEPTH.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (en && (cnt_q != SW'(DEPTH))) begin
      cnt_d = cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign primed = (cnt_q == SW'(DEPTH));

  // Tap mux from registered stages only; out-of-range taps clamp to the deepest stage.
  always_comb begin
    sel_eff   = sel;
    out       = '0;
    out_valid = 1'b0;
    if ((sel == '0) || (sel > SW'(DEPTH))) begin
      sel_eff = SW'(DEPTH);
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel_eff == SW'(i + 1)) begin
        out       = st[i].data;
        out_valid = st[i].valid;
      end
    end
  end

endmodule

// File: tb/tb_delay_buff.sv
// Self-checking bench for delay_buff: three configurations against a history model.
// Taps are also checked when DELAY_BUFF_TAPS_EN is defined.
`timescale 1ns/1ps
module tb_delay_buff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [3];
  logic       en_v    [3];
  logic       flush_v [3];
  logic       inv_v   [3];
  logic [7:0] in_v    [3];
  logic [2:0] sel_v   [3];

  logic [0:0] a_out;
  logic [7:0] b_out, c_out;
  logic       a_ov, b_ov, c_ov, a_pr, b_pr, c_pr;
`ifdef DELAY_BUFF_TAPS_EN
  logic [0:0]  a_taps;
  logic [31:0] b_taps;
  logic [23:0] c_taps;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  delay_buff #(.WIDTH(1), .DEPTH(1)) u_a (
    .clk(clk), .rst_n(rst_v[0]), .en(en_v[0]), .flush(flush_v[0]),
    .in(in_v[0][0:0]), .in_valid(inv_v[0]), .sel(sel_v[0][0:0]),
    .out(a_out), .out_valid(a_ov), .primed(a_pr)
`ifdef DELAY_BUFF_TAPS_EN
    , .taps(a_taps)
`endif
  );

  delay_buff #(.WIDTH(8), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_v[1]), .en(en_v[1]), .flush(flush_v[1]),
    .in(in_v[1]), .in_valid(inv_v[1]), .sel(sel_v[1]),
    .out(b_out), .out_valid(b_ov), .primed(b_pr)
`ifdef DELAY_BUFF_TAPS_EN
    , .taps(b_taps)
`endif
  );

  delay_buff #(.WIDTH(8), .DEPTH(3)) u_c (
    .clk(clk), .rst_n(rst_v[2]), .en(en_v[2]), .flush(flush_v[2]),
    .in(in_v[2]), .in_valid(inv_v[2]), .sel(sel_v[2][1:0]),
    .out(c_out), .out_valid(c_ov), .primed(c_pr)
`ifdef DELAY_BUFF_TAPS_EN
    , .taps(c_taps)
`endif
  );

  // Model: most recent shifted words first ({valid, data}), zeros where nothing shifted yet.
  logic [8:0] hist [3][8];
  int         pushes [3];

  function automatic int dep(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 3);
  endfunction

  function automatic int wid(input int k);
    return (k == 0) ? 1 : 8;
  endfunction

  function automatic logic [7:0] wmask(input int k);
    return (k == 0) ? 8'h01 : 8'hFF;
  endfunction

  function automatic logic [2:0] smask(input int k);
    return (k == 0) ? 3'd1 : ((k == 1) ? 3'd7 : 3'd3);
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!rst_v[k] || flush_v[k]) begin
        for (int j = 0; j < 8; j++) hist[k][j] = '0;
        pushes[k] = 0;
      end else if (en_v[k]) begin
        for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = {inv_v[k], in_v[k] & wmask(k)};
        pushes[k]++;
      end
    end
  endtask

  function automatic logic [8:0] exp_word(input int k);
    int s;
    s = int'(sel_v[k] & smask(k));
    if (s == 0 || s > dep(k)) s = dep(k);
    return hist[k][s-1];
  endfunction

  function automatic logic [9:0] dut_word(input int k);
    case (k)
      0:       return {a_pr, a_ov, 7'b0, a_out};
      1:       return {b_pr, b_ov, b_out};
      default: return {c_pr, c_ov, c_out};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [9:0]  d;
    logic [8:0]  e;
    logic [31:0] et;
    logic [31:0] dt;
    for (int k = 0; k < 3; k++) begin
      d = dut_word(k);
      e = exp_word(k);
      check($sformatf("inst%0d out", k), 32'(d[7:0]), 32'(e[7:0]));
      check($sformatf("inst%0d out_valid", k), 32'(d[8]), 32'(e[8]));
      check($sformatf("inst%0d primed", k), 32'(d[9]), 32'(pushes[k] >= dep(k)));
`ifdef DELAY_BUFF_TAPS_EN
      et = '0;
      for (int i = 0; i < dep(k); i++) et |= 32'(hist[k][i][7:0] & wmask(k)) << (i * wid(k));
      dt = (k == 0) ? 32'(a_taps) : ((k == 1) ? b_taps : 32'(c_taps));
      check($sformatf("inst%0d taps", k), dt, et);
`else
      et = '0;
      dt = '0;
`endif
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  // Flush line B while shifting a marker word, then confirm nothing survives on any tap.
  task automatic flush_b();
    en_v[1]    = 1'b1;
    flush_v[1] = 1'b1;
    in_v[1]    = 8'h5A;
    inv_v[1]   = 1'b1;
    step();
    flush_v[1] = 1'b0;
    en_v[1]    = 1'b0;
    check("flush primed", 32'(b_pr), 32'd0);
    for (int s = 1; s <= 4; s++) begin
      sel_v[1] = 3'(s);
      step();
      check("flush out_valid", 32'(b_ov), 32'd0);
      check("flush out", 32'(b_out), 32'd0);
    end
  endtask

  logic [7:0] tv [6];
  logic [7:0] ev [6];
  logic [2:0] sv [6];

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b0; en_v[k] = 1'b0; flush_v[k] = 1'b0;
      inv_v[k] = 1'b0; in_v[k] = '0;  sel_v[k] = '0;
    end
    step();
    step();
    check("reset out b", 32'(b_out), 32'd0);
    check("reset primed b", 32'(b_pr), 32'd0);
    for (int k = 0; k < 3; k++) rst_v[k] = 1'b1;

    // Basic 1-cycle register on A.
    sel_v[0] = 3'd1; en_v[0] = 1'b1; inv_v[0] = 1'b1;
    tv = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0};
    for (int i = 0; i < 4; i++) begin
      in_v[0] = tv[i];
      step();
      check("basic out", 32'(a_out), 32'(tv[i]));
      if (i == 0) check("basic primed", 32'(a_pr), 32'd1);
    end
    en_v[0] = 1'b0;

    // Tap sweep on B.
    en_v[1] = 1'b1; inv_v[1] = 1'b1; sel_v[1] = 3'd1;
    tv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      in_v[1] = tv[i];
      step();
    end
    en_v[1] = 1'b0; in_v[1] = 8'h00;
    sv = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd7};
    ev = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h11, 8'h11};
    for (int i = 0; i < 6; i++) begin
      sel_v[1] = sv[i];
      step();
      check("tap sweep", 32'(b_out), 32'(ev[i]));
    end

    // Stall: counter and stages hold, stalled input never enters.
    flush_b();
    sel_v[1] = 3'd1; en_v[1] = 1'b1; inv_v[1] = 1'b1;
    in_v[1] = 8'hA1; step();
    in_v[1] = 8'hA2; step();
    en_v[1] = 1'b0; in_v[1] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall hold", 32'(b_out), 32'hA2);
      check("stall primed", 32'(b_pr), 32'd0);
    end
    sel_v[1] = 3'd2; step();
    check("stall hold deep", 32'(b_out), 32'hA1);
    sel_v[1] = 3'd1; en_v[1] = 1'b1;
    in_v[1] = 8'hB3; step();
    check("primed after 3", 32'(b_pr), 32'd0);
    in_v[1] = 8'hB4; step();
    check("primed after 4", 32'(b_pr), 32'd1);
    en_v[1] = 1'b0;
    ev = '{8'hB4, 8'hB3, 8'hA2, 8'hA1, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      sel_v[1] = 3'(i + 1);
      step();
      check("resume line", 32'(b_out), 32'(ev[i]));
    end
    flush_b();

    // Valid tracking on C, tap 3.
    sel_v[2] = 3'd3; en_v[2] = 1'b1;
    tv = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 5; i++) begin
      inv_v[2] = tv[i][0];
      in_v[2]  = 8'(i + 1);
      step();
      if (i >= 2) check("valid track", 32'(c_ov), 32'(tv[i-2]));
    end
    en_v[2] = 1'b0;

    // Reset mid-stream on B, then immediate reload.
    sel_v[1] = 3'd1; en_v[1] = 1'b1; inv_v[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_v[1] = 8'(8'hC1 + i);
      step();
    end
    check("full primed", 32'(b_pr), 32'd1);
    rst_v[1] = 1'b0; step(); rst_v[1] = 1'b1;
    check("rst out", 32'(b_out), 32'd0);
    check("rst out_valid", 32'(b_ov), 32'd0);
    check("rst primed", 32'(b_pr), 32'd0);
`ifdef DELAY_BUFF_TAPS_EN
    check("rst taps", b_taps, 32'd0);
`endif
    in_v[1] = 8'hD1; step();
    check("post rst load", 32'(b_out), 32'hD1);
    check("post rst valid", 32'(b_ov), 32'd1);

    // Mixed traffic on all three lines.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 3; k++) begin
        en_v[k]    = ((i + k) % 4) != 0;
        flush_v[k] = (i == 17 + k);
        rst_v[k]   = !(i == 29 && k == 2);
        in_v[k]    = 8'(i * 37 + k * 11);
        inv_v[k]   = ((i + k) % 2) == 0;
        sel_v[k]   = 3'(i + k);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/delay_buff.md
# delay_buff

Parametrised, stallable delay line; the multi-bit, multi-stage successor to the single-register `buff`. Data words enter each enabled cycle and shift through DEPTH register stages, each stage carrying its own valid bit. A runtime tap select picks the delay seen at the output. A fill counter reports when the line has been completely primed since the last reset or flush. The block sits between a producer and any consumer that needs a fixed or selectable alignment delay.

## Interface
- `WIDTH`, 1: data word width in bits (≥1).
- `DEPTH`, 4: number of register stages, i.e. the maximum delay (≥1).
- `SW`, derived localparam $clog2(DEPTH+1): width of `sel` and of the fill counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `en` input 1: shift enable; when 0 the line holds (stall).
- `flush` input 1: synchronous clear of data, valid bits and fill counter.
- `in` input WIDTH: data word entering stage 0.
- `in_valid` input 1: valid qualifier for `in`.
- `sel` input SW: output tap, delay in enabled cycles (1..DEPTH).
- `out` output WIDTH: contents of stage `sel-1`.
- `out_valid` output 1: valid bit of stage `sel-1`.
- `primed` output 1: fill counter equals DEPTH.

## Operation
- Reset (`rst_n`=0 at an edge): every stage's data and valid bit is set to 0, and the fill counter is set to 0. Consequently `out`=0, `out_valid`=0 and `primed`=0.
- Priority at each edge is reset > flush > en > hold.
- Flush: clears all data, valid bits and the counter, exactly as reset does. The `in` word presented in the same cycle is discarded, even if `en`=1.
- Shift (`en`=1, no flush):
  - `stage[0]` ← {`in`, `in_valid`}.
  - `stage[i]` ← `stage[i-1]` for i=1..DEPTH-1.
  - The counter increments and saturates at DEPTH.
- Hold (`en`=0): all stages and the counter are unchanged. The output keeps presenting the selected stage.
- Invalid words (`in_valid`=0) still occupy a stage and still advance the counter. The counter measures cycles shifted, not valid words.
- Tap select:
  - `out`/`out_valid` is a combinational mux of the registered stages, with no logic from `in` to `out`.
  - `sel`=0 or `sel`>DEPTH clamps to DEPTH.
  - `sel` may change in any cycle; the output follows in the same cycle.
- `primed` is registered-derived: it is a compare of the counter only.

## Timing
- Latency from `in` to `out` is `sel` enabled edges. Stalled cycles do not count.
- With DEPTH=1 and `sel`=1, the block is exactly a 1-cycle register: `out` at edge n+1 equals `in` at edge n.
- `primed` rises on the edge completing the DEPTH-th enabled shift after a reset or flush. It stays high until the next reset or flush.
- Flush asserted with `en`=1: on the following cycle `out_valid`=0 for every tap and `primed`=0.
- `rst_n` deasserted mid-stream: the next enabled edge loads stage 0 normally. No recovery cycle is inserted.

## Configuration
- `DELAY_BUFF_TAPS_EN` defined: an extra output port `taps` of width WIDTH*DEPTH is present. Stage i occupies bits [i*WIDTH +: WIDTH].
- `DELAY_BUFF_TAPS_EN` undefined: the `taps` port is absent. All other behaviour is identical.

## Structure
- Package `delay_buff_pkg` holds:
  - the clog2 helper used for `SW`;
  - the default WIDTH and DEPTH constants;
  - the stage record type {data, valid}.
- Sub-module `delay_buff_stage`: one WIDTH+1-bit register with synchronous active-low reset, flush and enable. It is instantiated DEPTH times with a generate loop.
- The top level holds the fill counter, the clamp logic, the output mux and the optional tap flattening.

## Test plan
- Basic delay: WIDTH=1, DEPTH=1, `sel`=1. Drive `in` 0,1,0,1 on successive edges. Require `out` to be 0,0,1,0,1, one cycle late, and `primed`=1 after the first edge.
- Tap sweep: WIDTH=8, DEPTH=4, `en`=1. Drive `in` 0x11,0x22,0x33,0x44. After the 4th edge, require:
  - `sel`=1→0x44, `sel`=2→0x33, `sel`=3→0x22, `sel`=4→0x11;
  - `sel`=0 and `sel`=7 both →0x11.
- Stall: DEPTH=4. Load 0xA1,0xA2, then `en`=0 for 3 cycles with `in`=0xFF. Require the stages to be unchanged and the counter to hold at 2. Then resume and require 0xFF to be absent from the line.
- Primed/flush: DEPTH=4. Require `primed`=0 after 3 enabled edges and `primed`=1 after the 4th. Assert `flush` with `en`=1 and `in`=0x5A. Next cycle require `primed`=0, `out_valid`=0 for all `sel`, and 0x5A absent.
- Valid tracking: DEPTH=3. Drive `in_valid` 1,0,1 with `sel`=3. Require `out_valid` to be 1,0,1 on edges 3,4,5.
- Reset mid-stream: fill a DEPTH=4 line, then `rst_n`=0 for 1 cycle. Require `out`=0, `out_valid`=0 and `primed`=0. With `DELAY_BUFF_TAPS_EN` defined, also require `taps`=0.
